// File: rtl/instr_encoder.sv
// DLX instruction encoder feeding a DEPTH-entry output FIFO.
// Define ENC_RANGE_CHECK_EN to flag immediates that do not fit their field.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cls,
  input  logic [3:0]  in_I,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [2:0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [5:0]  alu_funct, alu_op;
  logic        alu_ok, alu_signed;
  logic [31:0] enc_word;
  logic        enc_bad, enc_err;
  logic        imm_used, imm_signed, imm_wide;

  always_comb begin
    alu_funct  = 6'h00;
    alu_op     = 6'h00;
    alu_ok     = 1'b1;
    alu_signed = 1'b0;
    case (in_I)
      4'd1:  begin alu_funct = 6'h20; alu_op = 6'h08; alu_signed = 1'b1; end
      4'd2:  begin alu_funct = 6'h22; alu_op = 6'h0A; alu_signed = 1'b1; end
      4'd3:  begin alu_funct = 6'h24; alu_op = 6'h0C; end
      4'd4:  begin alu_funct = 6'h25; alu_op = 6'h0D; end
      4'd5:  begin alu_funct = 6'h26; alu_op = 6'h0E; end
      4'd6:  begin alu_funct = 6'h04; alu_op = 6'h14; end
      4'd7:  begin alu_funct = 6'h06; alu_op = 6'h16; end
      4'd10: begin alu_funct = 6'h28; alu_op = 6'h18; alu_signed = 1'b1; end
      4'd11: begin alu_funct = 6'h2C; alu_op = 6'h1C; alu_signed = 1'b1; end
      4'd12: begin alu_funct = 6'h2A; alu_op = 6'h1A; alu_signed = 1'b1; end
      4'd13: begin alu_funct = 6'h29; alu_op = 6'h19; alu_signed = 1'b1; end
      4'd14: begin alu_funct = 6'h07; alu_op = 6'h17; end
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    enc_word   = 32'h0;
    enc_bad    = 1'b0;
    imm_used   = 1'b0;
    imm_signed = 1'b0;
    imm_wide   = 1'b0;
    case (in_cls)
      4'd0: begin
        enc_word = {6'h00, in_rs1, in_rs2, in_rd, 5'h00, alu_funct};
        enc_bad  = !alu_ok;
      end
      4'd1: begin
        enc_word   = {alu_op, in_rs1, in_rd, in_imm[15:0]};
        enc_bad    = !alu_ok;
        imm_used   = 1'b1;
        imm_signed = alu_signed;
      end
      4'd2: begin
        enc_word = {6'h23, in_rs1, in_rd, in_imm[15:0]};
        imm_used = 1'b1; imm_signed = 1'b1;
      end
      4'd3: begin
        enc_word = {6'h2B, in_rs1, in_rs2, in_imm[15:0]};
        imm_used = 1'b1; imm_signed = 1'b1;
      end
      4'd4, 4'd5: begin
        enc_word = {5'b00010, in_cls[0], in_rs1, 5'h00, in_imm[15:0]};
        imm_used = 1'b1; imm_signed = 1'b1;
      end
      4'd6, 4'd7: begin
        enc_word = {5'b00001, in_cls[0], in_imm[25:0]};
        imm_used = 1'b1; imm_signed = 1'b1; imm_wide = 1'b1;
      end
      4'd8, 4'd9: enc_word = {5'b01001, in_cls[0], in_rs1, 21'h0};
      4'd10: begin
        enc_word = {6'h0F, 5'h00, in_rd, in_imm[15:0]};
        imm_used = 1'b1;
      end
      default: enc_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_bad;
  always_comb begin
    range_bad = 1'b0;
    if (imm_used) begin
      if (!imm_signed)
        range_bad = |in_imm[31:16];
      else if (imm_wide)
        range_bad = in_imm[31:25] != {7{in_imm[25]}};
      else
        range_bad = in_imm[31:15] != {17{in_imm[15]}};
    end
  end
  assign enc_err = enc_bad | range_bad;
`else
  logic unused_range;
  assign unused_range = ^{imm_used, imm_signed, imm_wide, in_imm[31:26]};
  assign enc_err = enc_bad;
`endif

  logic [31:0]    mem_word [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push, pop;

  // Reset gates in_ready directly so nothing is accepted while it is held.
  assign in_ready  = reset_n && (count < FULL) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_word[rd_ptr] : 32'h0;
  assign out_err   = out_valid && mem_err[rd_ptr];
  assign level     = 3'(count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= enc_err ? 32'h0 : enc_word;
      mem_err[wr_ptr]  <= enc_err;
    end
  end
endmodule
